// File: rtl/count_seq_checker_pkg.sv
// count_seq_checker_pkg: state encodings and wrapping-increment helper for the sequence checker.
package count_seq_checker_pkg;
   localparam int STATE_W = 2;
   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2,
      ERROR   = 2'd3
   } state_e;
   function automatic logic [31:0] wrap_inc(input logic [31:0] v, input int unsigned w);
      return (v + 32'd1) & ((32'd1 << w) - 32'd1);
   endfunction
endpackage

// File: rtl/count_seq_checker_if.sv
// count_seq_checker_if: count stream in, lock/error/statistics status out.
interface count_seq_checker_if #(
   parameter int WIDTH  = 4,
   parameter int STAT_W = 8
) ();
   import count_seq_checker_pkg::*;
   logic [WIDTH-1:0]   count_in;
   logic               count_vld;
   logic               clear;
   logic               locked;
   logic               err_pulse;
   logic [STAT_W-1:0]  err_count;
   logic [STAT_W-1:0]  wrap_count;
   logic [WIDTH-1:0]   expected;
   logic [STATE_W-1:0] state;
   modport master (
      output count_in, count_vld, clear,
      input  locked, err_pulse, err_count, wrap_count, expected, state
   );
   modport slave (
      input  count_in, count_vld, clear,
      output locked, err_pulse, err_count, wrap_count, expected, state
   );
endinterface

// File: rtl/count_seq_checker_sat.sv
// sat_counter: saturating statistics counter; clear beats a same-cycle increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] value
);
   logic [W-1:0] value_q, value_d;
   always_comb value_d = clear ? '0 : (inc && value_q != '1) ? value_q + 1'b1 : value_q;
   always_ff @(posedge clk) begin
      if (!reset) value_q <= '0;
      else value_q <= value_d;
   end
   assign value = value_q;
endmodule

// File: rtl/count_seq_checker.sv
// count_seq_checker: locks onto a +1 count stream, flags mismatches and counts wraps.
// COUNT_SEQ_CHECKER_STICKY_ERR_EN makes a locked mismatch park in ERROR until clear.
module count_seq_checker
   import count_seq_checker_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int SYNC_LEN = 2,
   parameter int STAT_W   = 8
) (
   input logic               clk,
   input logic               reset,
   count_seq_checker_if.slave bus
);
   localparam int RUN_W = $clog2(SYNC_LEN + 1);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic             err_inc, wrap_en, match;
   logic [WIDTH-1:0] seed;
   logic [RUN_W-1:0] run_nx;
   assign match  = bus.count_in == expected_q;
   assign seed   = WIDTH'(wrap_inc(32'(bus.count_in), WIDTH));
   assign run_nx = run_q + 1'b1;
   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      run_d       = run_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;
      err_inc     = 1'b0;
      wrap_en     = 1'b0;
      // on a match count_in equals expected, so seed is also expected+1
      unique case (state_q)
         IDLE: if (bus.count_vld) begin
            expected_d = seed;
            run_d      = '0;
            state_d    = ACQUIRE;
         end
         ACQUIRE: if (bus.count_vld) begin
            expected_d = seed;
            run_d      = match ? run_nx : '0;
            if (match && run_nx == RUN_W'(SYNC_LEN)) begin
               state_d  = LOCKED;
               locked_d = 1'b1;
            end
         end
         LOCKED: if (bus.count_vld) begin
            if (match) begin
               expected_d = seed;
               wrap_en    = bus.count_in == '0;
            end else begin
               err_pulse_d = 1'b1;
               err_inc     = 1'b1;
               locked_d    = 1'b0;
               run_d       = '0;
`ifdef COUNT_SEQ_CHECKER_STICKY_ERR_EN
               state_d     = ERROR;
`else
               state_d     = ACQUIRE;
               expected_d  = seed;
`endif
            end
         end
         ERROR: begin
            locked_d = 1'b0;
            state_d  = bus.clear ? IDLE : ERROR;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         expected_q  <= '0;
         run_q       <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         run_q       <= run_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
      end
   end
   sat_counter #(.W(STAT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .inc   (err_inc),
      .value (bus.err_count)
   );
   sat_counter #(.W(STAT_W)) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (bus.clear),
      .inc   (wrap_en),
      .value (bus.wrap_count)
   );
   assign bus.state     = state_q;
   assign bus.locked    = locked_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.expected  = expected_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker: directed vectors, expected responses queued and checked by a monitor.
module tb_count_seq_checker;
   localparam logic [1:0] I = 2'd0, A = 2'd1, L = 2'd2, E = 2'd3;
   typedef struct {
      logic [1:0] st;
      logic       lk;
      logic       ep;
      logic [1:0] ec;
      logic [1:0] wc;
      logic [3:0] ex;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   exp_t q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   always #5 clk = ~clk;
   count_seq_checker_if #(.WIDTH(4), .STAT_W(2)) bus ();
   count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .STAT_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
      end
   endtask
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("state", 32'(bus.state), 32'(e.st));
         chk("locked", 32'(bus.locked), 32'(e.lk));
         chk("err_pulse", 32'(bus.err_pulse), 32'(e.ep));
         chk("err_count", 32'(bus.err_count), 32'(e.ec));
         chk("wrap_count", 32'(bus.wrap_count), 32'(e.wc));
         chk("expected", 32'(bus.expected), 32'(e.ex));
      end
   end
   task automatic s(input logic v, input logic [3:0] c, input logic clr, input logic [1:0] st,
                    input logic lk, input logic ep, input logic [1:0] ec, input logic [1:0] wc,
                    input logic [3:0] ex);
      @(negedge clk);
      reset         = 1'b1;
      bus.count_vld = v;
      bus.count_in  = c;
      bus.clear     = clr;
      q.push_back('{st, lk, ep, ec, wc, ex});
   endtask
   task automatic rst_cycle();
      @(negedge clk);
      reset         = 1'b0;
      bus.count_vld = 1'($urandom);
      bus.count_in  = 4'($urandom);
      bus.clear     = 1'($urandom);
      q.push_back('{I, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0});
   endtask
   initial begin
      bus.count_vld = 1'b0;
      bus.count_in  = '0;
      bus.clear     = 1'b0;
      rst_cycle();
      rst_cycle();
      s(1, 0, 0, A, 0, 0, 0, 0, 1);
      s(1, 1, 0, A, 0, 0, 0, 0, 2);
      s(1, 2, 0, L, 1, 0, 0, 0, 3);
      s(1, 3, 0, L, 1, 0, 0, 0, 4);
      for (int c = 4; c <= 14; c++) s(1, 4'(c), 0, L, 1, 0, 0, 0, 4'(c + 1));
      s(1, 15, 0, L, 1, 0, 0, 0, 0);
      s(1, 0, 0, L, 1, 0, 0, 1, 1);
      s(1, 1, 0, L, 1, 0, 0, 1, 2);
      s(1, 2, 0, L, 1, 0, 0, 1, 3);
      s(1, 3, 0, L, 1, 0, 0, 1, 4);
      s(1, 4, 0, L, 1, 0, 0, 1, 5);
`ifdef COUNT_SEQ_CHECKER_STICKY_ERR_EN
      s(1, 9, 0, E, 0, 1, 1, 1, 5);
      s(1, 10, 0, E, 0, 0, 1, 1, 5);
      s(1, 5, 0, E, 0, 0, 1, 1, 5);
      s(0, 4'($urandom), 1, I, 0, 0, 0, 0, 5);
      s(1, 10, 0, A, 0, 0, 0, 0, 11);
      s(1, 11, 0, A, 0, 0, 0, 0, 12);
      s(1, 12, 0, L, 1, 0, 0, 0, 13);
      s(1, 13, 0, L, 1, 0, 0, 0, 14);
      repeat (5) s(0, 4'($urandom), 0, L, 1, 0, 0, 0, 14);
      s(1, 14, 0, L, 1, 0, 0, 0, 15);
`else
      s(1, 9, 0, A, 0, 1, 1, 1, 10);
      s(0, 4'($urandom), 0, A, 0, 0, 1, 1, 10);
      s(1, 10, 0, A, 0, 0, 1, 1, 11);
      s(1, 11, 0, L, 1, 0, 1, 1, 12);
      s(1, 12, 0, L, 1, 0, 1, 1, 13);
      repeat (5) s(0, 4'($urandom), 0, L, 1, 0, 1, 1, 13);
      s(1, 13, 0, L, 1, 0, 1, 1, 14);
      s(1, 0, 0, A, 0, 1, 2, 1, 1);
      s(1, 1, 0, A, 0, 0, 2, 1, 2);
      s(1, 2, 0, L, 1, 0, 2, 1, 3);
      s(1, 7, 0, A, 0, 1, 3, 1, 8);
      s(1, 8, 0, A, 0, 0, 3, 1, 9);
      s(1, 9, 0, L, 1, 0, 3, 1, 10);
      s(1, 0, 0, A, 0, 1, 3, 1, 1);
      s(1, 1, 0, A, 0, 0, 3, 1, 2);
      s(1, 2, 0, L, 1, 0, 3, 1, 3);
      s(1, 9, 1, A, 0, 1, 0, 0, 10);
      s(1, 10, 0, A, 0, 0, 0, 0, 11);
      s(1, 11, 0, L, 1, 0, 0, 0, 12);
      s(1, 12, 0, L, 1, 0, 0, 0, 13);
      s(1, 13, 0, L, 1, 0, 0, 0, 14);
      s(1, 14, 0, L, 1, 0, 0, 0, 15);
      s(1, 15, 0, L, 1, 0, 0, 0, 0);
      s(1, 0, 1, L, 1, 0, 0, 0, 1);
`endif
      rst_cycle();
      s(0, 4'($urandom), 0, I, 0, 0, 0, 0, 0);
      @(negedge clk);
      bus.count_vld = 1'b0;
      bus.clear     = 1'b0;
      repeat (3) @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Receive end of the free-running counter interface. Samples a WIDTH-bit count stream and checks that each valid sample equals the previous one plus 1, modulo 2^WIDTH.
- Acquires lock on the sequence, then flags and counts sequence errors and wrap-arounds.
- Sits beside any counter instance as an in-design monitor and as a reusable checker for counter benches.

Parameters:
- WIDTH, 4, width of the monitored count.
- SYNC_LEN, 2, consecutive matching samples after seeding required to assert lock (≥1).
- STAT_W, 8, width of the saturating error and wrap statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge).
- count_in  in  WIDTH  observed counter value.
- count_vld  in  1  count_in is valid this cycle.
- clear  in  1  synchronous clear of statistics and of a sticky error.
- locked  out  1  sequence lock established.
- err_pulse  out  1  one-cycle pulse per detected mismatch while locked.
- err_count  out  STAT_W  saturating mismatch count.
- wrap_count  out  STAT_W  saturating count of locked wraps (all-ones to 0).
- expected  out  WIDTH  next expected value.
- state  out  2  current FSM state, for debug.

Behaviour:
- All outputs are registered. Every response appears the cycle after the sample edge.
- Reset (reset==0 at an edge): state=IDLE, locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0, run counter=0.
- Reset mid-operation overrides everything, including clear and count_vld.
- count_vld=0: state, expected and counters hold; err_pulse=0. Gaps never cause errors.
- FSM encodings: IDLE=0, ACQUIRE=1, LOCKED=2, ERROR=3.
- IDLE: on vld, expected<=count_in+1 (wrapping), run<=0, go to ACQUIRE.
- ACQUIRE:
  - vld and match: expected++, run++. When run reaches SYNC_LEN, go to LOCKED and set locked=1.
  - vld and mismatch: reseed expected<=count_in+1, run<=0, stay. No error is counted.
- LOCKED:
  - vld and match: expected++. If count_in==0, wrap_count++ (saturating).
  - vld and mismatch: err_pulse=1 for one cycle, err_count++ (saturating), locked<=0, expected<=count_in+1, run<=0. Next state is set by the optional feature.
- ERROR (sticky build only): locked=0. Samples are ignored. clear goes to IDLE.
- Arithmetic:
  - expected wraps modulo 2^WIDTH.
  - Statistics saturate at 2^STAT_W-1 and never wrap.
  - run counter is sized $clog2(SYNC_LEN+1).
- clear:
  - Zeroes err_count and wrap_count the next cycle.
  - If an increment occurs in the same cycle, clear wins (result 0).
  - clear does not affect lock, except in ERROR.
- Simultaneous mismatch and clear in LOCKED: err_pulse=1, err_count=0.

Optional Feature:
- Macro COUNT_SEQ_CHECKER_STICKY_ERR_EN.
- Defined: a LOCKED mismatch goes to ERROR and stays there until clear or reset. The first offending value is frozen in expected (no reseed).
- Undefined: a LOCKED mismatch goes straight to ACQUIRE with the reseed; ERROR is unreachable.

Decomposition:
- Package count_seq_checker_pkg:
  - state typedef with the four encodings.
  - STATE_W=2 constant.
  - Helper function for wrapping increment.
- Sub-module sat_counter (parameter W; ports clk, reset, clear, inc, value). Instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random count_in/vld → all outputs 0, state=0.
- Lock: vld samples 0,1,2,3 on consecutive cycles → locked=1 one cycle after sample 2, expected=4 after sample 3, err_count=0.
- Wrap: locked, feed 14,15,0,1 → wrap_count=1, err_pulse never high, expected=2.
- Error and relock (default build): locked at expected=5, feed 9 → err_pulse high exactly one cycle, err_count=1, locked=0, expected=10. Then feed 10,11 → locked=1 again.
- Gaps and saturation: feed 3, vld=0 for 5 cycles, then 4 → no error. With STAT_W=2, force 4 mismatches → err_count=3. Then clear with a simultaneous mismatch → err_count=0 and err_pulse=1.
- Sticky build (macro defined): mismatch 9 vs expected 5 → state=3, expected stays 5, further samples ignored. clear → state=0, counters 0.
